cpu_clk_ctrl: RTL and testbench

Run/step controller that sits directly downstream of the clock divider. It consumes the divider's slow square wave (`slow_clk`) as a plain data input and emits a one-`clk`-wide CPU clock-enable pulse (`cpu_en`) in the fast `clk` domain. The MIPS core advances one cycle per pulse, either free-running at the divided rate or single-stepped from a debounced board button. No logic is clocked by `slow_clk` itself.

---
 rtl/cpu_clk_ctrl_pkg.sv | 13 +
 rtl/cpu_clk_ctrl_if.sv | 25 ++
 rtl/cpu_clk_ctrl_step_debounce.sv | 48 ++++
 rtl/cpu_clk_ctrl.sv | 149 ++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and constants for the CPU run/step clock-enable controller.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2
    } state_e;

    // 10 ms of stable samples at 100 MHz
    localparam int DEB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Board/CPU-facing signal bundle of cpu_clk_ctrl; master = board+core, slave = controller.
interface cpu_clk_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             slow_clk;
    logic             sw_run;
    logic             btn_step;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             cpu_en;
    logic             running;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output slow_clk, sw_run, btn_step, pc, bp_addr, bp_valid,
        input  cpu_en, running, bp_hit, cycle_cnt
    );

    modport slave (
        input  slow_clk, sw_run, btn_step, pc, bp_addr, bp_valid,
        output cpu_en, running, bp_hit, cycle_cnt
    );
endinterface

// File: rtl/cpu_clk_ctrl_step_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-sample debounce, one-cycle press pulse.
module step_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level;
    // the DEB_CYCLES-th disagreeing sample flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_level <= r_s2;
                r_rise  <= r_s2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step controller turning the divided slow_clk into one-clk-wide CPU advance pulses.
// Optional breakpoint stop is enabled by defining CPU_CLK_CTRL_BREAK_EN.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    cpu_clk_ctrl_if.slave bus
);
    logic             r_slow_s1;
    logic             r_slow_s2;
    logic             r_slow_d;
    logic             r_tick;
    logic             r_run_s1;
    logic             r_run_s2;
    logic             r_cpu_en;
    logic             r_running;
    logic [CNT_W-1:0] r_cnt;
    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_step_req;
    logic             w_btn_level_unused;
    logic             w_fire;
    logic             w_bp_stop;
    logic             w_bp_match;
    logic             w_rearm;
    logic             w_bp_hit;

    // slow_clk is treated as data: synchronize, then register the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slow_s1 <= 1'b0;
            r_slow_s2 <= 1'b0;
            r_slow_d  <= 1'b0;
            r_tick    <= 1'b0;
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
        end else begin
            r_slow_s1 <= bus.slow_clk;
            r_slow_s2 <= r_slow_s1;
            r_slow_d  <= r_slow_s2;
            r_tick    <= r_slow_s2 & ~r_slow_d;
            r_run_s1  <= bus.sw_run;
            r_run_s2  <= r_run_s1;
        end
    end

    step_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn_step),
        .o_level (w_btn_level_unused),
        .o_rise  (w_step_req)
    );

`ifdef CPU_CLK_CTRL_BREAK_EN
    logic r_rearm;
    logic r_bp_hit;

    assign w_bp_match = bus.bp_valid && (bus.pc == bus.bp_addr);

    // After a breakpoint stop, RUN needs sw_run to be seen low before it re-engages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rearm  <= 1'b1;
            r_bp_hit <= 1'b0;
        end else begin
            if (w_bp_stop)
                r_rearm <= 1'b0;
            else if (!r_run_s2)
                r_rearm <= 1'b1;

            if (w_bp_stop)
                r_bp_hit <= 1'b1;
            else if (r_state == ST_PAUSE && w_state_nxt != ST_PAUSE)
                r_bp_hit <= 1'b0;
        end
    end

    assign w_rearm  = r_rearm;
    assign w_bp_hit = r_bp_hit;
`else
    wire w_unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_valid, w_bp_stop};

    assign w_bp_match = 1'b0;
    assign w_rearm    = 1'b1;
    assign w_bp_hit   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_bp_stop   = 1'b0;
        case (r_state)
            ST_PAUSE: begin
                if (r_run_s2 && w_rearm)
                    w_state_nxt = ST_RUN;
                else if (w_step_req)
                    w_state_nxt = ST_STEP;
            end
            ST_STEP: begin
                if (r_tick) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_RUN: begin
                // a pause request beats a coincident tick
                if (!r_run_s2) begin
                    w_state_nxt = ST_PAUSE;
                end else if (r_tick) begin
                    if (w_bp_match) begin
                        w_bp_stop   = 1'b1;
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_fire = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_PAUSE;
            r_cpu_en  <= 1'b0;
            r_running <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_en  <= w_fire;
            r_running <= (w_state_nxt == ST_RUN);
            if (w_fire)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.cpu_en    = r_cpu_en;
    assign bus.running   = r_running;
    assign bus.bp_hit    = w_bp_hit;
    assign bus.cycle_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: DEB_CYCLES=4, CNT_W=4, slow_clk period of 20 clk cycles.
module tb_cpu_clk_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cpu_clk_ctrl_if #(.CNT_W(4)) bus ();

    cpu_clk_ctrl #(
        .DEB_CYCLES (4),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   ph       = 0;
    int   exp_cnt  = 0;
    int   pulses   = 0;
    int   errors   = 0;
    int   checks   = 0;
    bit   exp_run  = 1'b0;
    bit   exp_once = 1'b0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, req, cyc);
        end
    endfunction

    // slow_clk source: rises when ph becomes 10; a pulse is expected 4 negedges later
    initial begin
        exp_t e;
        bus.slow_clk = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph == 19) ? 0 : ph + 1;
            bus.slow_clk = (ph >= 10);
            if (ph == 10 && (exp_run || exp_once)) begin
                exp_cnt = (exp_cnt + 1) % 16;
                e.cyc = cyc + 4;
                e.cnt = exp_cnt;
                sb_q.push_back(e);
                exp_once = 1'b0;
            end
        end
    end

    // monitor: every observed cpu_en must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cpu_en === 1'b1) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: cpu_en=1 at cyc %0d, none expected", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_cnt", int'(bus.cycle_cnt), e.cnt);
                end
            end
        end
    end

    task automatic wait_ph(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (ph != p && n < 40);
        if (ph != p) begin
            checks++;
            errors++;
            $display("FAIL wait_ph: phase %0d not reached, at %0d", p, ph);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.sw_run   = 1'b0;
        bus.btn_step = 1'b0;
        bus.pc       = 32'h0040_0000;
        bus.bp_addr  = 32'h0040_0010;
        bus.bp_valid = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_en", int'(bus.cpu_en), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_bp_hit", int'(bus.bp_hit), 0);
        chk("rst_cycle_cnt", int'(bus.cycle_cnt), 0);
        rst_n = 1'b1;

        p0 = pulses;
        repeat (200) @(negedge clk);
        chk("idle_pulses", pulses - p0, 0);

`ifndef CPU_CLK_CTRL_BREAK_EN
        bus.pc       = 32'h0040_0010;
        bus.bp_valid = 1'b1;
`endif
        // free run: 10 periods -> 10 pulses
        wait_ph(15);
        bus.sw_run = 1'b1;
        exp_run    = 1'b1;
        p0         = pulses;
        repeat (10) wait_ph(15);
        chk("run_pulses", pulses - p0, 10);
        chk("run_cnt", int'(bus.cycle_cnt), 10);
        chk("run_running", int'(bus.running), 1);

        // counter wrap at 4 bits: 17 pulses -> 1
        repeat (7) wait_ph(15);
        chk("wrap_cnt", int'(bus.cycle_cnt), 1);

        // run_s falls in the same cycle as tick (tick visible at ph 13)
        wait_ph(5);
        exp_run = 1'b0;
        wait_ph(11);
        bus.sw_run = 1'b0;
        wait_ph(13);
        chk("coll_running_pre", int'(bus.running), 1);
        wait_ph(14);
        chk("coll_running", int'(bus.running), 0);
        chk("coll_cpu_en", int'(bus.cpu_en), 0);
        wait_ph(15);
        chk("coll_cnt", int'(bus.cycle_cnt), 1);
        bus.pc       = 32'h0040_0000;
        bus.bp_valid = 1'b0;

        // reset mid-run
        wait_ph(15);
        bus.sw_run = 1'b1;
        exp_run    = 1'b1;
        repeat (2) wait_ph(15);
        chk("prerst_running", int'(bus.running), 1);
        wait_ph(5);
        exp_run = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("midrst_cpu_en", int'(bus.cpu_en), 0);
        chk("midrst_running", int'(bus.running), 0);
        chk("midrst_bp_hit", int'(bus.bp_hit), 0);
        chk("midrst_cycle_cnt", int'(bus.cycle_cnt), 0);
        exp_cnt    = 0;
        bus.sw_run = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        p0    = pulses;
        repeat (200) @(negedge clk);
        chk("postrst_pulses", pulses - p0, 0);
        chk("postrst_running", int'(bus.running), 0);

        // single step: 50-cycle hold -> exactly one pulse
        wait_ph(15);
        bus.btn_step = 1'b1;
        exp_once     = 1'b1;
        p0           = pulses;
        repeat (50) @(negedge clk);
        #1;
        bus.btn_step = 1'b0;
        repeat (2) wait_ph(15);
        chk("step_pulses", pulses - p0, 1);
        chk("step_cnt", int'(bus.cycle_cnt), 1);
        chk("step_running", int'(bus.running), 0);

        // 3-cycle glitch is shorter than the debounce window
        wait_ph(15);
        p0 = pulses;
        bus.btn_step = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        bus.btn_step = 1'b0;
        repeat (3) wait_ph(15);
        chk("glitch_pulses", pulses - p0, 0);

`ifdef CPU_CLK_CTRL_BREAK_EN
        bus.pc       = 32'h0040_0000;
        bus.bp_addr  = 32'h0040_0010;
        bus.bp_valid = 1'b1;
        wait_ph(15);
        bus.sw_run = 1'b1;
        exp_run    = 1'b1;
        repeat (2) wait_ph(15);
        wait_ph(5);
        exp_run = 1'b0;
        bus.pc  = 32'h0040_0010;
        wait_ph(15);
        chk("bp_hit_set", int'(bus.bp_hit), 1);
        chk("bp_running", int'(bus.running), 0);
        p0 = pulses;
        repeat (2) wait_ph(15);
        chk("bp_hold_pulses", pulses - p0, 0);

        wait_ph(15);
        bus.btn_step = 1'b1;
        exp_once     = 1'b1;
        p0           = pulses;
        repeat (10) @(negedge clk);
        #1;
        bus.btn_step = 1'b0;
        repeat (2) wait_ph(15);
        chk("bp_step_pulses", pulses - p0, 1);
        chk("bp_hit_clr", int'(bus.bp_hit), 0);
        chk("bp_step_running", int'(bus.running), 0);

        wait_ph(15);
        bus.sw_run = 1'b0;
        bus.pc     = 32'h0040_0014;
        wait_ph(15);
        bus.sw_run = 1'b1;
        exp_run    = 1'b1;
        p0         = pulses;
        repeat (2) wait_ph(15);
        chk("bp_resume_pulses", pulses - p0, 2);
        chk("bp_resume_running", int'(bus.running), 1);
        exp_run    = 1'b0;
        bus.sw_run = 1'b0;
`endif

        repeat (40) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
